hazard_control_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core, sitting beside ID/EX, directly upstream of the forwarding unit. Detects load-use, branch-flush, multi-cycle mul/div and data-memory-wait hazards, and drives per-stage stall, bubble and flush strobes. Owns the registered EX/MEM "instruction is a load" flag, which feeds the forwarding unit's `previous_instruction_is_lw` input. Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_control_unit_pkg.sv | 11 +
 rtl/hazard_control_unit_load_use_detector.sv | 26 ++
 rtl/hazard_control_unit.sv | 135 +++++++++++++
 tb/tb_hazard_control_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state encoding and
// the hard-wired zero register index.
package hazard_control_unit_pkg;

  localparam logic [1:0] RUN         = 2'd0;
  localparam logic [1:0] MULDIV_WAIT = 2'd1;
  localparam logic [1:0] MEM_WAIT    = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_control_unit_load_use_detector.sv
// Combinational load-use compare between the EX load and the ID consumer.
// Writes to x0 never create a dependency.
module load_use_detector
  import hazard_control_unit_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_is_load,
  output logic       load_use
);

  logic ex_writes_load;
  logic rs1_hit;
  logic rs2_hit;

  assign ex_writes_load = ex_is_load & ex_reg_write & (ex_rd != REG_X0);
  assign rs1_hit        = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit        = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use       = ex_writes_load & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: Mealy stall/bubble/flush strobes, the registered
// EX/MEM load flag for forwarding, and a saturating stall-cycle counter.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [4:0]         ex_rd,
  input  logic               ex_reg_write,
  input  logic               ex_is_load,
  input  logic               ex_muldiv_start,
  input  logic               muldiv_done,
  input  logic               branch_taken,
  input  logic               dmem_busy,
  output logic               stall_pc,
  output logic               stall_if_id,
  output logic               stall_id_ex,
  output logic               stall_ex_mem,
  output logic               bubble_id_ex,
  output logic               flush_if_id,
  output logic               mem_is_load,
  output logic [1:0]         state_o,
  output logic [COUNT_W-1:0] stall_cycles
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       pending_flush;
  logic       pending_flush_nxt;
  logic       load_use;

  load_use_detector u_load_use_detector (
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_is_load   (ex_is_load),
    .load_use     (load_use)
  );

  assign state_o = state;

  always_comb begin
    state_nxt         = state;
    pending_flush_nxt = pending_flush;
    stall_pc          = 1'b0;
    stall_if_id       = 1'b0;
    stall_id_ex       = 1'b0;
    stall_ex_mem      = 1'b0;
    bubble_id_ex      = 1'b0;
    flush_if_id       = 1'b0;
    case (state)
      RUN: begin
        if (dmem_busy) begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
          state_nxt = MEM_WAIT;
        end else if (ex_muldiv_start & ~muldiv_done) begin
          {stall_pc, stall_if_id, stall_id_ex} = 3'b111;
          state_nxt = MULDIV_WAIT;
        end else if (branch_taken & ~ex_muldiv_start) begin
          // Taken branch squashes any load-use in ID, so no stall here.
          flush_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end else if (load_use) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end
      end
      MULDIV_WAIT: begin
        if (dmem_busy) begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
          state_nxt = MEM_WAIT;
        end else if (muldiv_done) begin
          state_nxt = RUN;
        end else begin
          {stall_pc, stall_if_id, stall_id_ex} = 3'b111;
        end
      end
      MEM_WAIT: begin
        if (dmem_busy) begin
          {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
          if (branch_taken) pending_flush_nxt = 1'b1;
        end else begin
          flush_if_id       = pending_flush | branch_taken;
          bubble_id_ex      = pending_flush | branch_taken;
          pending_flush_nxt = 1'b0;
          state_nxt         = RUN;
        end
      end
      default: begin
        state_nxt         = RUN;
        pending_flush_nxt = 1'b0;
      end
    endcase
    if (!rst_n) begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      bubble_id_ex = 1'b0;
      flush_if_id  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      mem_is_load   <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      state         <= state_nxt;
      pending_flush <= pending_flush_nxt;
      // A held EX stage sends a bubble, not the load, into MEM.
      if (!stall_ex_mem) begin
        if (stall_id_ex) mem_is_load <= 1'b0;
        else             mem_is_load <= ex_is_load & ex_reg_write & (ex_rd != REG_X0);
      end
      if (stall_pc && (stall_cycles != {COUNT_W{1'b1}}))
        stall_cycles <= stall_cycles + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (COUNT_W=2 so saturation is reachable);
// each step pushes the expected observation vector and pops it for comparison.
module tb_hazard_control_unit;

  localparam int COUNT_W = 2;
  localparam int W = 6 + 2 + 1 + COUNT_W;

  logic               clk;
  logic               rst_n;
  logic               id_valid;
  logic [4:0]         id_rs1;
  logic [4:0]         id_rs2;
  logic               id_uses_rs1;
  logic               id_uses_rs2;
  logic [4:0]         ex_rd;
  logic               ex_reg_write;
  logic               ex_is_load;
  logic               ex_muldiv_start;
  logic               muldiv_done;
  logic               branch_taken;
  logic               dmem_busy;
  logic               stall_pc;
  logic               stall_if_id;
  logic               stall_id_ex;
  logic               stall_ex_mem;
  logic               bubble_id_ex;
  logic               flush_if_id;
  logic               mem_is_load;
  logic [1:0]         state_o;
  logic [COUNT_W-1:0] stall_cycles;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  hazard_control_unit #(.COUNT_W(COUNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_is_load      (ex_is_load),
    .ex_muldiv_start (ex_muldiv_start),
    .muldiv_done     (muldiv_done),
    .branch_taken    (branch_taken),
    .dmem_busy       (dmem_busy),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .stall_id_ex     (stall_id_ex),
    .stall_ex_mem    (stall_ex_mem),
    .bubble_id_ex    (bubble_id_ex),
    .flush_if_id     (flush_if_id),
    .mem_is_load     (mem_is_load),
    .state_o         (state_o),
    .stall_cycles    (stall_cycles)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobes = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex, flush_if_id}
  function automatic logic [W-1:0] mk(logic [5:0] strobes, logic [1:0] st, logic mil,
                                      logic [COUNT_W-1:0] cnt);
    return {strobes, st, mil, cnt};
  endfunction

  task automatic idle();
    id_valid        = 1'b0;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    id_uses_rs1     = 1'b0;
    id_uses_rs2     = 1'b0;
    ex_rd           = 5'd0;
    ex_reg_write    = 1'b0;
    ex_is_load      = 1'b0;
    ex_muldiv_start = 1'b0;
    muldiv_done     = 1'b0;
    branch_taken    = 1'b0;
    dmem_busy       = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    ex_rd        = rd;
    ex_reg_write = 1'b1;
    ex_is_load   = 1'b1;
  endtask

  task automatic drive_consumer(input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid    = 1'b1;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_uses_rs1 = 1'b1;
    id_uses_rs2 = 1'b1;
  endtask

  // Inputs are already driven at the falling edge; record expectation, sample, advance.
  task automatic step(input string tag, input logic [W-1:0] e);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    exp_q.push_back(e);
    #1;
    obs   = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex, flush_if_id,
             state_o, mem_is_load, stall_cycles};
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n     = 1'b0;
    dmem_busy = 1'b1;
    @(negedge clk);
    step("reset_forced_zero", mk(6'b000000, 2'd0, 1'b0, 2'd0));

    // lw x5 in EX, add x6,x5,x1 in ID
    rst_n = 1'b1;
    idle();
    drive_load(5'd5);
    drive_consumer(5'd5, 5'd1);
    step("load_use_stall", mk(6'b110010, 2'd0, 1'b0, 2'd0));
    idle();
    drive_consumer(5'd5, 5'd1);
    step("load_use_forward", mk(6'b000000, 2'd0, 1'b1, 2'd1));
    idle();
    step("load_use_drain", mk(6'b000000, 2'd0, 1'b0, 2'd1));

    // load to x0 with a dependent read of x0
    drive_load(5'd0);
    drive_consumer(5'd0, 5'd0);
    step("x0_no_stall", mk(6'b000000, 2'd0, 1'b0, 2'd1));
    idle();
    step("x0_no_mem_load", mk(6'b000000, 2'd0, 1'b0, 2'd1));

    // mul/div with done 4 cycles after start; counter saturates at 3
    ex_muldiv_start = 1'b1;
    step("muldiv_start", mk(6'b111000, 2'd0, 1'b0, 2'd1));
    step("muldiv_wait1", mk(6'b111000, 2'd1, 1'b0, 2'd2));
    step("muldiv_wait2", mk(6'b111000, 2'd1, 1'b0, 2'd3));
    step("muldiv_wait3", mk(6'b111000, 2'd1, 1'b0, 2'd3));
    muldiv_done = 1'b1;
    step("muldiv_done", mk(6'b000000, 2'd1, 1'b0, 2'd3));
    idle();
    step("muldiv_back_run", mk(6'b000000, 2'd0, 1'b0, 2'd3));

    // reset asserted while in MULDIV_WAIT
    ex_muldiv_start = 1'b1;
    step("rst_md_start", mk(6'b111000, 2'd0, 1'b0, 2'd3));
    rst_n = 1'b0;
    step("rst_md_forced", mk(6'b000000, 2'd1, 1'b0, 2'd3));
    rst_n = 1'b1;
    idle();
    step("rst_md_after", mk(6'b000000, 2'd0, 1'b0, 2'd0));

    // independent load enters MEM, then dmem_busy 3 cycles with branch in the 2nd
    drive_load(5'd7);
    step("indep_load", mk(6'b000000, 2'd0, 1'b0, 2'd0));
    idle();
    dmem_busy = 1'b1;
    step("dmem_busy1", mk(6'b111100, 2'd0, 1'b1, 2'd0));
    branch_taken = 1'b1;
    step("dmem_busy2_branch", mk(6'b111100, 2'd2, 1'b1, 2'd1));
    branch_taken = 1'b0;
    step("dmem_busy3", mk(6'b111100, 2'd2, 1'b1, 2'd2));
    dmem_busy = 1'b0;
    step("dmem_exit_flush", mk(6'b000011, 2'd2, 1'b1, 2'd3));
    step("dmem_after", mk(6'b000000, 2'd0, 1'b0, 2'd3));

    // taken branch together with a load-use
    drive_load(5'd9);
    drive_consumer(5'd3, 5'd9);
    branch_taken = 1'b1;
    step("branch_squash_lu", mk(6'b000011, 2'd0, 1'b0, 2'd3));
    idle();
    step("branch_after", mk(6'b000000, 2'd0, 1'b1, 2'd3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
